// File: rtl/game_pkg.sv
// Shared types and helpers for the bullet scheduler: FSM state encoding,
// default slot count and slot-index width.
package game_pkg;

    localparam int BULLET_NUM_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        COOL = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_free_picker.sv
// Round-robin free-slot picker: rotate the free mask so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_free_picker
    import game_pkg::*;
#(
    parameter int N  = BULLET_NUM_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_free,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [IW-1:0] o_sel,
    output logic          o_any_free
);

    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_off;

    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N; i++)
            w_rot[i] = i_free[(i + int'(i_rr_ptr)) % N];
    end

    // Descending scan so the lowest rotated index wins.
    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (w_rot[i]) w_off = IW'(i);
    end

    assign o_sel      = IW'((int'(w_off) + int'(i_rr_ptr)) % N);
    assign o_any_free = |i_free;

endmodule

// File: rtl/bullet_scheduler.sv
// Synchronous shoot-key scheduler: synchronise/edge-detect the key, pick a free
// bullet slot round-robin, enforce a refire cooldown and gate on game_over.
// Optional one-deep request latch enabled by defining BULLET_SCHED_BUFFER_EN.
module bullet_scheduler
    import game_pkg::*;
#(
    parameter int BULLET_NUM  = BULLET_NUM_DEF,
    parameter int COOLDOWN    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_en,
    input  logic                          shoot_key,
    input  logic                          game_over,
    input  logic [BULLET_NUM-1:0]         bullet_active,
    output logic [BULLET_NUM-1:0]         fire,
    output logic [$clog2(BULLET_NUM)-1:0] fire_slot,
    output logic [$clog2(BULLET_NUM):0]   free_cnt,
    output logic                          drop
);

    localparam int IW = $clog2(BULLET_NUM);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_key_d;
    logic [BULLET_NUM-1:0]  r_active;
    logic [BULLET_NUM-1:0]  r_pending;
    state_t                 r_state;
    logic [IW-1:0]          r_rr;
    logic [7:0]             r_cnt;
    logic [BULLET_NUM-1:0]  r_fire;
    logic [IW-1:0]          r_fire_slot;
    logic [IW:0]            r_free_cnt;
    logic                   r_drop;
    logic                   r_req;

    logic                   w_press;
    logic                   w_want;
    logic                   w_go;
    logic [BULLET_NUM-1:0]  w_free;
    logic [BULLET_NUM-1:0]  w_fire_vec;
    logic [IW-1:0]          w_sel;
    logic                   w_any;
    logic [IW:0]            w_free_num;
    logic                   w_drop_nx;
    logic                   w_req_nx;

    assign w_press = r_sync[SYNC_STAGES-1] & ~r_key_d;
    // A slot just fired stays reserved until its bullet reports active.
    assign w_free  = ~r_active & ~r_pending;

    rr_free_picker #(.N(BULLET_NUM), .IW(IW)) u_picker (
        .i_free     (w_free),
        .i_rr_ptr   (r_rr),
        .o_sel      (w_sel),
        .o_any_free (w_any)
    );

    always_comb begin
        w_free_num = '0;
        for (int i = 0; i < BULLET_NUM; i++)
            w_free_num = w_free_num + (IW+1)'(w_free[i]);
    end

`ifdef BULLET_SCHED_BUFFER_EN
    assign w_want = w_press | r_req;
`else
    assign w_want = w_press;
`endif

    assign w_go       = (r_state == IDLE) & w_want & ~game_over & w_any;
    assign w_fire_vec = w_go ? (BULLET_NUM'(1) << w_sel) : '0;

`ifdef BULLET_SCHED_BUFFER_EN
    always_comb begin
        w_req_nx  = r_req;
        w_drop_nx = 1'b0;
        if (game_over) begin
            w_req_nx  = 1'b0;
            w_drop_nx = w_press;
        end else if (w_go) begin
            w_req_nx  = 1'b0;
            w_drop_nx = w_press & r_req;
        end else if (w_press) begin
            if (r_req) w_drop_nx = 1'b1;
            else       w_req_nx  = 1'b1;
        end
    end
`else
    assign w_req_nx  = 1'b0;
    assign w_drop_nx = w_press & ~w_go;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= '0;
            r_key_d     <= 1'b0;
            r_active    <= '0;
            r_pending   <= '0;
            r_state     <= IDLE;
            r_rr        <= '0;
            r_cnt       <= '0;
            r_fire      <= '0;
            r_fire_slot <= '0;
            r_free_cnt  <= (IW+1)'(BULLET_NUM);
            r_drop      <= 1'b0;
            r_req       <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], shoot_key};
            r_key_d    <= r_sync[SYNC_STAGES-1];
            r_active   <= bullet_active;
            r_pending  <= (r_pending & ~bullet_active) | w_fire_vec;
            r_fire     <= w_fire_vec;
            r_drop     <= w_drop_nx;
            r_req      <= w_req_nx;
            r_free_cnt <= w_free_num;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_state     <= FIRE;
                        r_fire_slot <= w_sel;
                        r_rr        <= (w_sel == IW'(BULLET_NUM - 1)) ? '0 : w_sel + 1'b1;
                        r_cnt       <= 8'(COOLDOWN);
                    end
                end
                // Fire pulse is on the outputs this cycle; ticks here are ignored.
                FIRE: r_state <= COOL;
                COOL: begin
                    if (tick_en) begin
                        if (r_cnt <= 8'd1) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fire      = r_fire;
    assign fire_slot = r_fire_slot;
    assign free_cnt  = r_free_cnt;
    assign drop      = r_drop;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Scoreboard bench for bullet_scheduler (BULLET_NUM=4, COOLDOWN=8): directed
// presses push expected fire/drop events, a negedge monitor pops and compares.
module tb_bullet_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en;
    logic       shoot_key;
    logic       game_over;
    logic [3:0] bullet_active;
    logic [3:0] fire;
    logic [1:0] fire_slot;
    logic [2:0] free_cnt;
    logic       drop;

    typedef struct packed {
        logic [3:0] fire;
        logic [1:0] slot;
        logic       drop;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    bullet_scheduler #(.BULLET_NUM(4), .COOLDOWN(8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_en       (tick_en),
        .shoot_key     (shoot_key),
        .game_over     (game_over),
        .bullet_active (bullet_active),
        .fire          (fire),
        .fire_slot     (fire_slot),
        .free_cnt      (free_cnt),
        .drop          (drop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1 && (fire !== 4'b0 || drop !== 1'b0)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got fire=%b slot=%0d drop=%b", fire, fire_slot, drop);
            end else begin
                e = q.pop_front();
                if (fire !== e.fire || drop !== e.drop || (e.fire != 4'b0 && fire_slot !== e.slot)) begin
                    bad++;
                    $display("FAIL event got fire=%b slot=%0d drop=%b want fire=%b slot=%0d drop=%b",
                             fire, fire_slot, drop, e.fire, e.slot, e.drop);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic exp_fire(input logic [3:0] f, input logic [1:0] s);
        exp_t e;
        e.fire = f; e.slot = s; e.drop = 1'b0;
        q.push_back(e);
    endtask

    task automatic exp_drop();
        exp_t e;
        e.fire = '0; e.slot = '0; e.drop = 1'b1;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        shoot_key = 1'b1;
        cyc(4);
        shoot_key = 1'b0;
        cyc(3);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_en = 1'b1;
            cyc(1);
            tick_en = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        rst = 1'b1; tick_en = 1'b0; shoot_key = 1'b0; game_over = 1'b0; bullet_active = '0;
        cyc(3);
        chk("rst_fire", int'(fire), 0);
        chk("rst_fire_slot", int'(fire_slot), 0);
        chk("rst_drop", int'(drop), 0);
        chk("rst_free_cnt", int'(free_cnt), 4);
        rst = 1'b0;
        cyc(2);

        // First press from reset takes slot 0; pending holds it before active.
        exp_fire(4'b0001, 2'd0);
        press();
        chk("pending_free_cnt", int'(free_cnt), 3);
        bullet_active = 4'b0001;
        tick(7);
        exp_drop();
        press();
        tick(1);
        cyc(2);
        chk("free_cnt_one_busy", int'(free_cnt), 3);

        // Slot 1, then a press with 3 ticks of cooldown remaining.
        exp_fire(4'b0010, 2'd1);
        press();
        bullet_active = 4'b0011;
        tick(5);
`ifdef BULLET_SCHED_BUFFER_EN
        press();
        exp_fire(4'b0100, 2'd2);
        tick(3);
        cyc(3);
`else
        exp_drop();
        press();
        tick(3);
        exp_fire(4'b0100, 2'd2);
        press();
`endif
        bullet_active = 4'b0111;
        tick(8);

        exp_fire(4'b1000, 2'd3);
        press();
        bullet_active = 4'b1111;
        tick(8);
        cyc(2);
        chk("free_cnt_all_busy", int'(free_cnt), 0);

        // No free slot.
`ifdef BULLET_SCHED_BUFFER_EN
        press();
        exp_drop();
        press();
        game_over = 1'b1;
        cyc(2);
        game_over = 1'b0;
`else
        exp_drop();
        press();
`endif
        bullet_active = 4'b0000;
        cyc(3);
        chk("free_cnt_all_free", int'(free_cnt), 4);

        // rr_ptr wraps past 0 onto slot 3 with slots 1,2 busy, then back to 0.
        exp_fire(4'b0001, 2'd0);
        press();
        bullet_active = 4'b0001;
        tick(8);
        bullet_active = 4'b0110;
        cyc(3);
        chk("free_cnt_mid_busy", int'(free_cnt), 2);
        exp_fire(4'b1000, 2'd3);
        press();
        bullet_active = 4'b1110;
        tick(8);
        exp_fire(4'b0001, 2'd0);
        press();
        bullet_active = 4'b1111;
        tick(8);
        bullet_active = 4'b0000;
        cyc(3);

        // game_over blocks firing.
        game_over = 1'b1;
        exp_drop();
        press();
        game_over = 1'b0;
        cyc(2);

        // Held key yields exactly one press.
        exp_fire(4'b0010, 2'd1);
        shoot_key = 1'b1;
        cyc(10);
        bullet_active = 4'b0010;
        tick(8);
        cyc(974);
        shoot_key = 1'b0;
        bullet_active = 4'b0000;
        cyc(5);

        // Reset right after a fire clears pending, pointer and cooldown.
        exp_fire(4'b0100, 2'd2);
        shoot_key = 1'b1;
        cyc(3);
        shoot_key = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("post_rst_fire_slot", int'(fire_slot), 0);
        cyc(1);
        chk("post_rst_free_cnt", int'(free_cnt), 4);
        exp_fire(4'b0001, 2'd0);
        press();
        bullet_active = 4'b0001;
        cyc(10);

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
